// File: rtl/spi_xfer_arbiter_if.sv
// Byte handshake between the frame arbiter and the single-CS SPI master.
// The master modport is the arbiter side; the slave modport is the SPI master side.
interface spi_xfer_arbiter_if;
  logic [7:0] o_tx_byte;
  logic       o_tx_dv;
  logic [2:0] o_tx_count;
  logic       i_tx_ready;
  logic       i_rx_dv;
  logic [7:0] i_rx_byte;

  modport master (output o_tx_byte, o_tx_dv, o_tx_count,
                  input  i_tx_ready, i_rx_dv, i_rx_byte);
  modport slave  (input  o_tx_byte, o_tx_dv, o_tx_count,
                  output i_tx_ready, i_rx_dv, i_rx_byte);
endinterface

// File: rtl/spi_xfer_arbiter.sv
// Round-robin share of one SPI master between two 4-byte frame requesters.
// Optional byte timeout compiled in with SPI_ARB_TIMEOUT_EN.
module spi_xfer_arbiter #(
  parameter int NUM_BYTES    = 4,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic               clk40M,
  input  logic               nRst,
  input  logic               req0,
  input  logic [31:0]        frame0,
  output logic               gnt0,
  output logic               done0,
  input  logic               req1,
  input  logic [31:0]        frame1,
  output logic               gnt1,
  output logic               done1,
  output logic [31:0]        rdata,
  output logic               err,
  output logic               busy,
  spi_xfer_arbiter_if.master spi
);
  localparam logic [1:0] LAST_IDX = 2'(NUM_BYTES - 1);
  localparam logic [2:0] NB       = 3'(NUM_BYTES);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
  state_t state, state_nx;

  logic [31:0] frame_q, shadow, rdata_q;
  logic [1:0]  idx;
  logic [2:0]  rx_cnt;
  logic        owner, last, wait_first, win1, tx_dv, abort, byte_ok;

  // On a tie the requester not served last wins; last=1 after reset favours req0.
  assign win1    = req1 & (~req0 | ~last);
  // The master needs a cycle to drop ready after a strobe.
  assign byte_ok = ~wait_first & spi.i_tx_ready;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [12:0] to_cnt;
  logic        aborted;

  always_ff @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      to_cnt  <= '0;
      aborted <= 1'b0;
    end else begin
      if (tx_dv || state == IDLE || state == DONE) to_cnt <= '0;
      else                                         to_cnt <= to_cnt + 13'd1;
      if (state == IDLE) aborted <= 1'b0;
      else if (abort)    aborted <= 1'b1;
    end
  end

  assign abort = (state == SEND || state == WAIT) && (to_cnt == 13'(TIMEOUT_CLKS));
  assign err   = (state == DONE) & aborted;
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    tx_dv    = 1'b0;
    case (state)
      IDLE: if (req0 | req1) state_nx = SEND;
      SEND: begin
        if (abort) state_nx = DONE;
        else if (spi.i_tx_ready) begin
          tx_dv    = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (abort)        state_nx = DONE;
        else if (byte_ok) state_nx = (idx == LAST_IDX) ? DONE : SEND;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      frame_q    <= '0;
      shadow     <= '0;
      rdata_q    <= '0;
      idx        <= '0;
      rx_cnt     <= '0;
      owner      <= 1'b0;
      last       <= 1'b1;
      wait_first <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
    end else begin
      state      <= state_nx;
      wait_first <= tx_dv;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      if (state == IDLE) begin
        if (req0 | req1) begin
          frame_q <= win1 ? frame1 : frame0;
          owner   <= win1;
          last    <= win1;
          gnt0    <= ~win1;
          gnt1    <= win1;
          shadow  <= '0;  // bytes never received on abort read as zero
        end
        idx    <= '0;
        rx_cnt <= '0;
      end else begin
        if (state == WAIT && byte_ok && idx != LAST_IDX) idx <= idx + 2'd1;
        if (spi.i_rx_dv && rx_cnt < NB) begin
          shadow[{rx_cnt[1:0], 3'b000} +: 8] <= spi.i_rx_byte;
          rx_cnt <= rx_cnt + 3'd1;
        end
        if (state == DONE) rdata_q <= shadow;
      end
    end
  end

  // The shadow is presented directly in DONE so rdata is valid alongside doneN.
  assign rdata          = (state == DONE) ? shadow : rdata_q;
  assign done0          = (state == DONE) & ~owner;
  assign done1          = (state == DONE) & owner;
  assign busy           = (state != IDLE);
  assign spi.o_tx_dv    = tx_dv;
  assign spi.o_tx_byte  = tx_dv ? frame_q[{idx, 3'b000} +: 8] : 8'h00;
  assign spi.o_tx_count = NB;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter with an echoing SPI master model (MISO = ~MOSI)
// and a frame-level scoreboard checked every cycle.
module tb_spi_xfer_arbiter;
  logic        clk40M = 1'b0;
  logic        nRst   = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, hang = 1'b0;
  logic [31:0] frame0 = '0, frame1 = '0;
  logic        gnt0, gnt1, done0, done1, err, busy;
  logic [31:0] rdata;

  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, gnt_cnt1 = 0, last_done = -100;
  logic [7:0] mosi_log[$];
  logic [7:0] fb[$];

  spi_xfer_arbiter_if sp();

  spi_xfer_arbiter #(.NUM_BYTES(4), .TIMEOUT_CLKS(64)) dut (
    .clk40M(clk40M), .nRst(nRst),
    .req0(req0), .frame0(frame0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .frame1(frame1), .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .err(err), .busy(busy), .spi(sp.master)
  );

  always #5 clk40M = ~clk40M;
  always @(posedge clk40M) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Master model: take a strobed byte, drop ready, echo the inverted byte, re-arm.
  initial begin : master_model
    logic [7:0] b;
    sp.i_tx_ready = 1'b1;
    sp.i_rx_dv    = 1'b0;
    sp.i_rx_byte  = 8'h00;
    forever begin
      @(negedge clk40M);
      if (!hang) sp.i_tx_ready = 1'b1;
      if (nRst && sp.o_tx_dv) begin
        b = sp.o_tx_byte;
        @(posedge clk40M); #1 sp.i_tx_ready = 1'b0;
        repeat (2) @(posedge clk40M);
        #1 sp.i_rx_dv = 1'b1; sp.i_rx_byte = ~b;
        @(posedge clk40M); #1 sp.i_rx_dv = 1'b0; sp.i_rx_byte = 8'h00;
        if (!hang) sp.i_tx_ready = 1'b1;
      end
    end
  end

  // Scoreboard: frame ownership, fairness, byte order and read word.
  logic        open = 1'b0, own = 1'b0, mlast = 1'b1, p_req0 = 1'b0, p_req1 = 1'b0;
  logic [31:0] p_frame0 = '0, p_frame1 = '0, exp_frame = '0, er, fw;

  always @(negedge clk40M) begin
    if (!nRst) begin
      chk("reset_outs", {gnt0, gnt1, done0, done1, err, busy, sp.o_tx_dv, sp.o_tx_byte}, 32'h0);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_tx_count", sp.o_tx_count, 32'd4);
      open  = 1'b0;
      mlast = 1'b1;
      fb.delete();
    end else begin
      chk("tx_count", sp.o_tx_count, 32'd4);
      if (!sp.o_tx_dv) chk("tx_byte_idle", sp.o_tx_byte, 32'h0);
      if (gnt0 | gnt1) begin
        chk("gnt_winner", {gnt0, gnt1},
            (p_req0 & p_req1) ? (mlast ? 2'b10 : 2'b01) : {p_req0, p_req1});
        chk("gnt_while_open", open, 1'b0);
        chk("gnt_gap", (cyc - last_done) >= 2, 1'b1);
        own       = gnt1;
        mlast     = gnt1;
        exp_frame = gnt1 ? p_frame1 : p_frame0;
        open      = 1'b1;
        if (gnt1) gnt_cnt1++;
        fb.delete();
      end
      chk("busy", busy, open);
      if (sp.o_tx_dv) begin
        fb.push_back(sp.o_tx_byte);
        mosi_log.push_back(sp.o_tx_byte);
      end
      if (done0 | done1) begin
        chk("done_open", open, 1'b1);
        chk("done_owner", {done0, done1}, own ? 2'b01 : 2'b10);
        chk("err", err, hang);
        er = '0;
        fw = '0;
        for (int i = 0; i < fb.size() && i < 4; i++) begin
          er[8*i +: 8] = ~fb[i];
          fw[8*i +: 8] = fb[i];
        end
        chk("rdata_model", rdata, er);
        if (!hang) begin
          chk("nbytes", fb.size(), 32'd4);
          chk("mosi_frame", fw, exp_frame);
        end
        done_cnt++;
        last_done = cyc;
        open      = 1'b0;
      end
    end
    p_req0   = req0;
    p_req1   = req1;
    p_frame0 = frame0;
    p_frame1 = frame1;
  end

  function automatic logic ev(input int sel);
    case (sel)
      0:       return gnt0;
      1:       return gnt1;
      2:       return done0;
      3:       return done1;
      default: return gnt0 | gnt1;
    endcase
  endfunction

  task automatic wait_ev(input int sel, input string nm, output int at);
    int  n = 0;
    bit  hit = 0;
    at = -1;
    while (!hit && n < 400) begin
      @(negedge clk40M);
      if (ev(sel)) begin hit = 1; at = cyc; end
      n++;
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL %s: got timeout want event", nm);
    end
  endtask

  task automatic wait_bytes(input int n);
    int k = 0;
    while (mosi_log.size() < n && k < 200) begin @(negedge clk40M); k++; end
    if (mosi_log.size() < n) begin
      checks++; errors++;
      $display("FAIL wait_bytes: got %0d want %0d", mosi_log.size(), n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk40M); #1 nRst = 1'b0;
    repeat (3) @(posedge clk40M);
    #1 nRst = 1'b1;
  endtask

  function automatic logic [31:0] log_word();
    logic [31:0] w = '0;
    for (int i = 0; i < mosi_log.size() && i < 4; i++) w[8*i +: 8] = mosi_log[i];
    return w;
  endfunction

  initial begin
    int d, g, n0;
    #1 nRst = 1'b0;
    repeat (3) @(posedge clk40M);
    #1 nRst = 1'b1;

    // Single request
    mosi_log.delete();
    @(posedge clk40M); #1 frame0 = 32'h44332211; req0 = 1'b1;
    wait_ev(0, "t1_gnt0", g);
    @(posedge clk40M); #1 req0 = 1'b0;
    wait_ev(2, "t1_done0", d);
    chk("t1_rdata", rdata, 32'hBBCCDDEE);
    chk("t1_err", err, 1'b0);
    chk("t1_nbytes", mosi_log.size(), 32'd4);
    chk("t1_mosi", log_word(), 32'h44332211);

    // Tie after reset, then tie again
    do_reset();
    @(posedge clk40M); #1 frame0 = 32'hA0A1A2A3; frame1 = 32'hB0B1B2B3; req0 = 1'b1; req1 = 1'b1;
    wait_ev(4, "tie_gnt", g);
    chk("tie_first", {gnt0, gnt1}, 2'b10);
    @(posedge clk40M); #1 req0 = 1'b0;
    wait_ev(2, "tie_done0", d);
    wait_ev(1, "tie_gnt1", g);
    chk("tie_gap", g - d, 32'd2);
    @(posedge clk40M); #1 req1 = 1'b0;
    wait_ev(3, "tie_done1", d);
    @(posedge clk40M); #1 req0 = 1'b1; req1 = 1'b1;
    wait_ev(4, "tie2_gnt", g);
    chk("tie2_first", {gnt0, gnt1}, 2'b10);
    @(posedge clk40M); #1 req0 = 1'b0;
    wait_ev(2, "tie2_done0", d);
    wait_ev(1, "tie2_gnt1", g);
    @(posedge clk40M); #1 req1 = 1'b0;
    wait_ev(3, "tie2_done1", d);

    // Late request during byte 2
    mosi_log.delete();
    @(posedge clk40M); #1 frame0 = 32'hA1B2C3D4; req0 = 1'b1;
    wait_ev(0, "late_gnt0", g);
    @(posedge clk40M); #1 req0 = 1'b0;
    wait_bytes(2);
    @(posedge clk40M); #1 frame1 = 32'h55667788; req1 = 1'b1;
    n0 = gnt_cnt1;
    wait_ev(2, "late_done0", d);
    chk("late_no_early_gnt1", gnt_cnt1, n0);
    chk("late_mosi", log_word(), 32'hA1B2C3D4);
    chk("late_rdata0", rdata, 32'h5E4D3C2B);
    wait_ev(1, "late_gnt1", g);
    chk("late_gap", g - d, 32'd2);
    @(posedge clk40M); #1 req1 = 1'b0;
    wait_ev(3, "late_done1", d);
    chk("late_rdata1", rdata, 32'hAA998877);

    // Frame changed one cycle after grant
    mosi_log.delete();
    @(posedge clk40M); #1 frame0 = 32'h0F1E2D3C; req0 = 1'b1;
    wait_ev(0, "chg_gnt0", g);
    @(posedge clk40M); #1 req0 = 1'b0; frame0 = 32'hFFFFFFFF;
    wait_ev(2, "chg_done0", d);
    chk("chg_mosi", log_word(), 32'h0F1E2D3C);
    chk("chg_rdata", rdata, 32'hF0E1D2C3);

`ifdef SPI_ARB_TIMEOUT_EN
    // Master stalls after byte 1
    mosi_log.delete();
    hang = 1'b1;
    @(posedge clk40M); #1 frame0 = 32'h000000A5; req0 = 1'b1;
    wait_ev(0, "to_gnt0", g);
    @(posedge clk40M); #1 req0 = 1'b0;
    wait_ev(2, "to_done0", d);
    chk("to_err", err, 1'b1);
    chk("to_rdata", rdata, 32'h0000005A);
    @(posedge clk40M); #1 hang = 1'b0;
    repeat (4) @(posedge clk40M);
`endif

    // Reset in the middle of byte 3
    mosi_log.delete();
    @(posedge clk40M); #1 frame0 = 32'h99887766; req0 = 1'b1;
    wait_ev(0, "rst_gnt0", g);
    @(posedge clk40M); #1 req0 = 1'b0;
    wait_bytes(3);
    n0 = done_cnt;
    @(posedge clk40M); #1 nRst = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_dv", sp.o_tx_dv, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_done", {done0, done1}, 2'b00);
    repeat (3) @(posedge clk40M);
    #1 nRst = 1'b1;
    repeat (6) @(posedge clk40M);
    chk("rst_no_done", done_cnt, n0);
    #1 frame1 = 32'h12345678; req1 = 1'b1;
    wait_ev(4, "rst_gnt", g);
    chk("rst_winner", {gnt0, gnt1}, 2'b01);
    @(posedge clk40M); #1 req1 = 1'b0;
    wait_ev(3, "rst_done1", d);
    chk("rst_rdata1", rdata, 32'hEDCBA987);

    repeat (4) @(posedge clk40M);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
